// File: rtl/bf16_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bf16_mul_seq                                                 |
// | Description : Sequential bfloat16 multiplier. Special operands resolve in  |
// |               one cycle; other operands take an 8-cycle shift-add multiply,|
// |               then normalize, optional gradual-underflow shifting, and     |
// |               round-to-nearest-even.                                       |
// |               Optional build macro BF16_MUL_FTZ_EN: flush tiny results to  |
// |               signed zero instead of producing subnormals.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bf16_mul_seq #(
  parameter int NEXP   = 8,
  parameter int NSIG   = 7,
  parameter int NTYPES = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 a_sign,
  input  logic                 b_sign,
  input  logic [NEXP-1:0]      a_exp,
  input  logic [NEXP-1:0]      b_exp,
  input  logic [NSIG:0]        a_sig,
  input  logic [NSIG:0]        b_sig,
  input  logic [NEXP-1:0]      a_shift,
  input  logic [NEXP-1:0]      b_shift,
  input  logic [NTYPES-1:0]    a_flags,
  input  logic [NTYPES-1:0]    b_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NEXP+NSIG:0]   result,
  output logic [3:0]           exc
);

  localparam int c_sw   = NSIG + 1;              // significand width incl. leading one
  localparam int c_pw   = 2 * c_sw;              // raw product width
  localparam int c_ew   = NEXP + 2;              // signed working exponent width
  localparam int c_cw   = $clog2(c_sw);          // multiplier bit counter width
  localparam int c_bias = (1 << (NEXP - 1)) - 1;
  localparam int c_emax = (1 << NEXP) - 1;

  // Classification flag bit positions
  localparam int c_f_inf  = 0;
  localparam int c_f_snan = 1;
  localparam int c_f_qnan = 2;
  localparam int c_f_zero = 3;
  localparam int c_f_sub  = 4;
  localparam int c_f_norm = 5;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_mul    = 3'd1;
  localparam logic [2:0] c_st_norm   = 3'd2;
  localparam logic [2:0] c_st_denorm = 3'd3;
  localparam logic [2:0] c_st_round  = 3'd4;
  localparam logic [2:0] c_st_done   = 3'd5;

  logic [2:0]               r_state;
  logic [2:0]               w_next;
  logic                     r_sign;
  logic [c_sw-1:0]          r_a_sig;
  logic [c_sw-1:0]          r_b_sig;
  logic [c_cw-1:0]          r_cnt;
  logic [3:0]               r_dcnt;
  logic [c_pw-1:0]          r_prod;
  logic signed [c_ew-1:0]   r_exp;
  logic [c_sw-1:0]          r_sig;
  logic                     r_guard;
  logic                     r_sticky;
  logic                     r_tiny;

  logic signed [c_ew-1:0]   w_ea;
  logic signed [c_ew-1:0]   w_eb;
  logic signed [c_ew-1:0]   w_pexp;
  logic                     w_sign;
  logic                     w_a_nan;
  logic                     w_b_nan;
  logic                     w_special;
  logic [NEXP+NSIG:0]       w_spec_res;
  logic [3:0]               w_spec_exc;
  logic [c_pw-1:0]          w_addend;
  logic signed [c_ew-1:0]   w_norm_exp;
  logic                     w_norm_tiny;
  logic                     w_inexact;
  logic                     w_up;
  logic [c_sw:0]            w_sum;
  logic [c_sw-1:0]          w_rsig;
  logic signed [c_ew-1:0]   w_rexp;
  logic [NEXP-1:0]          w_enc;
  logic [NEXP+NSIG:0]       w_round_res;
  logic [3:0]               w_round_exc;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_next;
  end

  // Next-state sequencing through the multiply pipeline
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:   if (in_valid) w_next = w_special ? c_st_done : c_st_mul;
      c_st_mul:    if (r_cnt == c_cw'(c_sw - 1)) w_next = c_st_norm;
`ifdef BF16_MUL_FTZ_EN
      c_st_norm:   w_next = c_st_round;
`else
      c_st_norm:   w_next = w_norm_tiny ? c_st_denorm : c_st_round;
`endif
      // Stop once the exponent is about to reach 1, or after 9 shifts
      c_st_denorm: if ((r_exp == '0) || (r_dcnt == 4'd8)) w_next = c_st_round;
      c_st_round:  w_next = c_st_done;
      c_st_done:   if (out_ready) w_next = c_st_idle;
      default:     w_next = c_st_idle;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (r_state == c_st_idle);
    out_valid = (r_state == c_st_done);
  end

  // Operand decode, special-case results, multiply step, and rounding
  always_comb begin
    w_sign = a_sign ^ b_sign;
    w_ea   = a_flags[c_f_sub] ? (c_ew'(1) - c_ew'(a_shift)) : c_ew'(a_exp);
    w_eb   = b_flags[c_f_sub] ? (c_ew'(1) - c_ew'(b_shift)) : c_ew'(b_exp);
    w_pexp = w_ea + w_eb - c_ew'(c_bias);

    w_a_nan   = a_flags[c_f_snan] | a_flags[c_f_qnan];
    w_b_nan   = b_flags[c_f_snan] | b_flags[c_f_qnan];
    w_special = ~((a_flags[c_f_norm] | a_flags[c_f_sub]) &
                  (b_flags[c_f_norm] | b_flags[c_f_sub]));

    w_spec_exc = 4'b0000;
    if (w_a_nan | w_b_nan) begin
      w_spec_res    = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
      w_spec_exc[3] = a_flags[c_f_snan] | b_flags[c_f_snan];
    end else if ((a_flags[c_f_inf] & b_flags[c_f_zero]) |
                 (a_flags[c_f_zero] & b_flags[c_f_inf])) begin
      w_spec_res    = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
      w_spec_exc[3] = 1'b1;
    end else if (a_flags[c_f_inf] | b_flags[c_f_inf]) begin
      w_spec_res = {w_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end else begin
      w_spec_res = {w_sign, {(NEXP+NSIG){1'b0}}};
    end

    w_addend = r_b_sig[r_cnt] ? ({{c_sw{1'b0}}, r_a_sig} << r_cnt) : '0;

    w_norm_exp  = r_exp + {{(c_ew-1){1'b0}}, r_prod[c_pw-1]};
    w_norm_tiny = w_norm_exp[c_ew-1] | (w_norm_exp == '0);

    w_inexact = r_guard | r_sticky;
    w_up      = r_guard & (r_sticky | r_sig[0]);
    w_sum     = {1'b0, r_sig} + {{c_sw{1'b0}}, w_up};
    w_rsig    = w_sum[c_sw] ? w_sum[c_sw:1] : w_sum[c_sw-1:0];
    w_rexp    = r_exp + {{(c_ew-1){1'b0}}, w_sum[c_sw]};
    // A significand without its leading one is subnormal; one that rounded
    // into the leading position is already the minimum normal (exponent 1)
    w_enc     = w_rsig[c_sw-1] ? w_rexp[NEXP-1:0] : '0;

    w_round_res = {r_sign, w_enc, w_rsig[NSIG-1:0]};
    w_round_exc = {2'b00, r_tiny & w_inexact, w_inexact};
    if (!w_rexp[c_ew-1] && (w_rexp >= c_ew'(c_emax))) begin
      w_round_res = {r_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      w_round_exc = 4'b0101;
    end
`ifdef BF16_MUL_FTZ_EN
    if (r_tiny) begin
      w_round_res = {r_sign, {(NEXP+NSIG){1'b0}}};
      w_round_exc = 4'b0011;
    end
`endif
  end

  // Datapath registers advanced by the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_a_sig  <= '0;
      r_b_sig  <= '0;
      r_cnt    <= '0;
      r_dcnt   <= '0;
      r_prod   <= '0;
      r_exp    <= '0;
      r_sig    <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_tiny   <= 1'b0;
      result   <= '0;
      exc      <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_sign   <= w_sign;
            r_a_sig  <= a_sig;
            r_b_sig  <= b_sig;
            r_exp    <= w_pexp;
            r_cnt    <= '0;
            r_dcnt   <= '0;
            r_prod   <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_tiny   <= 1'b0;
            if (w_special) begin
              result <= w_spec_res;
              exc    <= w_spec_exc;
            end
          end
        end
        c_st_mul: begin
          r_prod <= r_prod + w_addend;
          r_cnt  <= r_cnt + 1'b1;
        end
        c_st_norm: begin
          r_exp  <= w_norm_exp;
          r_tiny <= w_norm_tiny;
          if (r_prod[c_pw-1]) begin
            r_sig    <= r_prod[c_pw-1 -: c_sw];
            r_guard  <= r_prod[c_pw-1-c_sw];
            r_sticky <= |r_prod[c_pw-2-c_sw:0];
          end else begin
            r_sig    <= r_prod[c_pw-2 -: c_sw];
            r_guard  <= r_prod[c_pw-2-c_sw];
            r_sticky <= |r_prod[c_pw-3-c_sw:0];
          end
        end
        c_st_denorm: begin
          r_sig    <= r_sig >> 1;
          r_guard  <= r_sig[0];
          r_sticky <= r_sticky | r_guard;
          r_exp    <= r_exp + c_ew'(1);
          r_dcnt   <= r_dcnt + 4'd1;
        end
        c_st_round: begin
          result <= w_round_res;
          exc    <= w_round_exc;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bf16_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bf16_mul_seq                                              |
// | Description : Directed self-checking bench for bf16_mul_seq. A value-level |
// |               bf16 product model supplies expected result, flags and       |
// |               latency; literal vectors pin the model.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bf16_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp, a_sig, b_sig, a_shift, b_shift;
  logic [5:0]  a_flags, b_flags;
  logic [15:0] result;
  logic [3:0]  exc;

  bf16_mul_seq #(.NEXP(8), .NSIG(7), .NTYPES(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_sig(a_sig), .b_sig(b_sig), .a_shift(a_shift), .b_shift(b_shift),
    .a_flags(a_flags), .b_flags(b_flags), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .exc(exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [3:0]  x;
    int          lat;
  } vec_t;

`ifdef BF16_MUL_FTZ_EN
  localparam logic [15:0] L6_R  = 16'h0000;
  localparam logic [3:0]  L6_X  = 4'b0011;
  localparam int          L6_L  = 11;
  localparam int          L14_L = 11;
  localparam logic [15:0] L15_R = 16'h0000;
  localparam int          L15_L = 11;
`else
  localparam logic [15:0] L6_R  = 16'h0040;
  localparam logic [3:0]  L6_X  = 4'b0000;
  localparam int          L6_L  = 12;
  localparam int          L14_L = 20;
  localparam logic [15:0] L15_R = 16'h0080;
  localparam int          L15_L = 12;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc = 0;
  bit          pending = 0;
  bit          seen = 0;
  bit          chk_ready_next = 0;
  logic [15:0] exp_r;
  logic [3:0]  exp_x;
  int          exp_l;
  vec_t        vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Split a bf16 pattern into the pre-classified operand fields the block expects
  function automatic void enc_op(input logic [15:0] v, output logic s, output logic [7:0] e,
                                 output logic [7:0] sg, output logic [7:0] sh, output logic [5:0] fl);
    logic [6:0] f;
    f = v[6:0];
    s = v[15]; e = v[14:7]; sg = {1'b1, f}; sh = 8'd0; fl = 6'd0;
    if (e == 8'hFF) begin
      if (f == 7'd0)  fl[0] = 1'b1;
      else if (f[6])  fl[2] = 1'b1;
      else            fl[1] = 1'b1;
    end else if (e == 8'd0) begin
      if (f == 7'd0) fl[3] = 1'b1;
      else begin
        fl[4] = 1'b1;
        sg = {1'b0, f};
        while (!sg[7]) begin sg = sg << 1; sh = sh + 8'd1; end
      end
    end else begin
      fl[5] = 1'b1;
    end
  endfunction

  // Value-level bf16 product: exact integer product, then RNE onto the bf16 grid
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [3:0] x, output int lat);
    bit s, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, tiny, up, inex;
    int ea, eb, fa, fb, ma, mb, m, be, sh, eenc, k;
    longint p, q, rem, half;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]); eb = int'(b[14:7]); fa = int'(a[6:0]); fb = int'(b[6:0]);
    nan_a = (ea == 255) && (fa != 0); nan_b = (eb == 255) && (fb != 0);
    snan_a = nan_a && (fa < 64);      snan_b = nan_b && (fb < 64);
    inf_a = (ea == 255) && (fa == 0); inf_b = (eb == 255) && (fb == 0);
    zero_a = (ea == 0) && (fa == 0);  zero_b = (eb == 0) && (fb == 0);
    x = 4'b0000; lat = 1;
    if (nan_a || nan_b) begin r = 16'h7FC0; x[3] = snan_a || snan_b; return; end
    if ((inf_a && zero_b) || (zero_a && inf_b)) begin r = 16'h7FC0; x[3] = 1'b1; return; end
    if (inf_a || inf_b) begin r = {s, 8'hFF, 7'h00}; return; end
    if (zero_a || zero_b) begin r = {s, 15'h0000}; return; end
    ma = (ea == 0) ? fa : 128 + fa; if (ea == 0) ea = 1;
    mb = (eb == 0) ? fb : 128 + fb; if (eb == 0) eb = 1;
    p = longint'(ma) * longint'(mb);
    m = 0;
    for (int i = 0; i < 16; i++) if (p[i]) m = i;
    be   = ea + eb - 127 + (m - 14);
    tiny = (be < 1);
    k    = tiny ? (((1 - be) > 9) ? 9 : (1 - be)) : 0;
`ifdef BF16_MUL_FTZ_EN
    if (tiny) begin r = {s, 15'h0000}; x = 4'b0011; lat = 11; return; end
`endif
    lat = 11 + k;
    sh  = (m - 7) + (tiny ? (1 - be) : 0);
    if (sh > 40) sh = 40;
    if (sh <= 0) begin
      q = p << (-sh); rem = 0; up = 1'b0;
    end else begin
      q    = p >> sh;
      rem  = p & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      up   = (rem > half) || ((rem == half) && q[0]);
    end
    inex = (rem != 0);
    q = q + (up ? 1 : 0);
    if (!tiny) begin
      if (q == 256) begin q = 128; be = be + 1; end
      eenc = be;
    end else begin
      eenc = (q >= 128) ? 1 : 0;
    end
    if (eenc >= 255) begin
      r = {s, 8'hFF, 7'h00}; x = 4'b0101;
    end else begin
      r = {s, eenc[7:0], q[6:0]}; x = {2'b00, tiny && inex, inex};
    end
  endfunction

  // Compare process: every cycle out_valid is high the outputs must match the model
  always @(negedge clk) begin
    if (chk_ready_next) begin
      chk("in_ready_after_handshake", in_ready, 1);
      chk_ready_next = 0;
    end
    if (out_valid) begin
      if (!pending) begin
        checks++; errors++;
        $display("FAIL spurious_out_valid: got out_valid=1 required 0 (cycle %0d)", cyc);
      end else begin
        if (!seen) begin chk("latency", cyc - acc + 1, exp_l); seen = 1; end
        chk("result", result, exp_r);
        chk("exc", exc, exp_x);
        chk("in_ready_while_done", in_ready, 0);
        if (out_ready) begin pending = 0; chk_ready_next = 1; end
      end
    end
  end

  task automatic wait_ready();
    int wt = 0;
    while (!in_ready && wt < 50) begin @(negedge clk); wt++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 required 1 within 50 cycles");
    end
  endtask

  task automatic scramble();
    a_sign = 1'($urandom); b_sign = 1'($urandom);
    a_exp = 8'($urandom); b_exp = 8'($urandom); a_sig = 8'($urandom); b_sig = 8'($urandom);
    a_shift = 8'($urandom); b_shift = 8'($urandom);
    a_flags = 6'($urandom); b_flags = 6'($urandom);
  endtask

  task automatic run_op(input vec_t v, input bit hold);
    logic [15:0] mr; logic [3:0] mx; int ml; int wt;
    model(v.a, v.b, mr, mx, ml);
    chk("model_result", mr, v.r);
    chk("model_exc", mx, v.x);
    chk("model_latency", ml, v.lat);
    wait_ready();
    enc_op(v.a, a_sign, a_exp, a_sig, a_shift, a_flags);
    enc_op(v.b, b_sign, b_exp, b_sig, b_shift, b_flags);
    in_valid = 1'b1; out_ready = !hold;
    exp_r = mr; exp_x = mx; exp_l = ml;
    @(posedge clk); #1;
    acc = cyc; seen = 0; pending = 1;
    @(negedge clk);
    if (ml > 5) begin
      // Offers while busy must be ignored and must not disturb the result
      repeat (3) begin scramble(); @(negedge clk); end
    end
    in_valid = 1'b0;
    scramble();
    if (hold) begin
      wt = 0;
      while (!out_valid && wt < 40) begin @(negedge clk); wt++; end
      repeat (5) @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    wt = 0;
    while (pending && wt < 60) begin @(negedge clk); wt++; end
    if (pending) begin
      checks++; errors++;
      $display("FAIL result_timeout: got no completed handshake required one for %h*%h", v.a, v.b);
      pending = 0;
    end
    out_ready = 1'b1;
  endtask

  task automatic reset_mid_mul();
    wait_ready();
    enc_op(16'h3F80, a_sign, a_exp, a_sig, a_shift, a_flags);
    enc_op(16'h4000, b_sign, b_exp, b_sig, b_shift, b_flags);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 16'h0000);
    chk("abort_exc", exc, 4'h0);
    repeat (20) @(negedge clk);
    chk("abort_no_result", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    scramble();
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 16'h0000);
    chk("reset_exc", exc, 4'h0);
    rst = 1'b0;

    vecs.push_back('{16'h3F80, 16'h4000, 16'h4000, 4'b0000, 11});
    vecs.push_back('{16'h3FC0, 16'h3FC0, 16'h4010, 4'b0000, 11});
    vecs.push_back('{16'h7F80, 16'h0000, 16'h7FC0, 4'b1000, 1});
    vecs.push_back('{16'h7F81, 16'h3F80, 16'h7FC0, 4'b1000, 1});
    vecs.push_back('{16'h7F00, 16'h7F00, 16'h7F80, 4'b0101, 11});
    vecs.push_back('{16'h0080, 16'h3F00, L6_R,     L6_X,    L6_L});
    vecs.push_back('{16'h3F80, 16'hBF80, 16'hBF80, 4'b0000, 11});
    vecs.push_back('{16'hFF80, 16'h4000, 16'hFF80, 4'b0000, 1});
    vecs.push_back('{16'h8000, 16'h3F80, 16'h8000, 4'b0000, 1});
    vecs.push_back('{16'h7FC0, 16'h0000, 16'h7FC0, 4'b0000, 1});
    vecs.push_back('{16'h3F81, 16'h3F81, 16'h3F82, 4'b0001, 11});
    vecs.push_back('{16'h3F81, 16'h3FC0, 16'h3FC2, 4'b0001, 11});
    vecs.push_back('{16'h0001, 16'h4300, 16'h0080, 4'b0000, 11});
    vecs.push_back('{16'h0080, 16'h0080, 16'h0000, 4'b0011, L14_L});
    vecs.push_back('{16'h3F7F, 16'h0080, L15_R,    4'b0011, L15_L});
    vecs.push_back('{16'h7F7F, 16'h3F81, 16'h7F80, 4'b0101, 11});

    foreach (vecs[i]) run_op(vecs[i], 1'b0);
    run_op(vecs[1], 1'b1);
    reset_mid_mul();
    run_op(vecs[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test required completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
